// File: rtl/tod_pkg.sv
// Shared Time-of-Day field layout, constants and helpers for the ToD counter
// and its downstream timestamp-offset users.
package tod_pkg;

  localparam int TOD_W   = 96;
  localparam int SEC_MSB = 95;
  localparam int SEC_LSB = 48;
  localparam int NS_MSB  = 47;
  localparam int NS_LSB  = 16;
  localparam int FNS_MSB = 15;
  localparam int FNS_LSB = 0;

  localparam int SEC_W = SEC_MSB - SEC_LSB + 1;
  localparam int NS_W  = NS_MSB - NS_LSB + 1;
  localparam int FNS_W = FNS_MSB - FNS_LSB + 1;
  localparam int SUM_W = 50;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
    logic [FNS_W-1:0] fns;
  } tod_t;

  // 32'h8000_0000 has no positive twin; its "magnitude" stays 2^31 and fails the bound.
  function automatic logic adj_in_range(input logic [31:0] adj);
    logic [31:0] mag;
    mag = adj[31] ? (~adj + 32'd1) : adj;
    return mag <= (NS_PER_SEC - 32'd1);
  endfunction

endpackage

// File: rtl/tod_ns_normalize.sv
// Folds a signed {ns,fns} sum back into [0, 1e9) ns, carrying into or
// borrowing from the 48-bit seconds field (modulo 2^48).
module tod_ns_normalize
  import tod_pkg::*;
(
  input  logic signed [SUM_W-1:0] i_sum,
  input  logic [SEC_W-1:0]        i_sec,
  output tod_t                    o_tod,
  output logic                    o_carry,
  output logic                    o_borrow
);

  localparam int NSX_W = SUM_W - FNS_W;
  localparam logic signed [NSX_W-1:0] NS_LIM = NSX_W'(NS_PER_SEC);

  logic signed [NSX_W-1:0] w_ns;
  logic signed [NSX_W-1:0] w_ns_fold;

  assign w_ns = i_sum[SUM_W-1:FNS_W];

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ns_fold = w_ns;
    o_carry   = 1'b0;
    o_borrow  = 1'b0;
    o_tod.sec = i_sec;
    if (w_ns >= NS_LIM) begin
      w_ns_fold = w_ns - NS_LIM;
      o_carry   = 1'b1;
      o_tod.sec = i_sec + SEC_W'(1);
    end else if (w_ns < NSX_W'(0)) begin
      w_ns_fold = w_ns + NS_LIM;
      o_borrow  = 1'b1;
      o_tod.sec = i_sec - SEC_W'(1);
    end
    o_tod.ns  = w_ns_fold[NS_W-1:0];
    o_tod.fns = i_sum[FNS_W-1:0];
  end

endmodule

// File: rtl/tod_local_counter.sv
// Free-running 96-bit ToD generator: loadable, offset-adjustable, with a
// retunable per-cycle increment, a PPS pulse and a request-reject pulse.
module tod_local_counter
  import tod_pkg::*;
#(
  parameter logic [3:0]  DEF_PERIOD_NS  = 4'd6,
  parameter logic [15:0] DEF_PERIOD_FNS = 16'h6666
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [TOD_W-1:0]  load_tod,
  input  logic              adj_valid,
  input  logic [31:0]       adj_ns,
  input  logic              period_valid,
  input  logic [3:0]        period_ns,
  input  logic [15:0]       period_fns,
  output logic [TOD_W-1:0]  tod_out,
  output logic              tod_valid,
  output logic              pps,
  output logic              err
);

  tod_t        r_tod;
  logic        r_tod_valid;
  logic        r_pps;
  logic        r_err;
  logic [3:0]  r_period_ns;
  logic [15:0] r_period_fns;

  logic                    w_load_ok;
  logic                    w_adj_ok;
  logic                    w_period_bad;
  logic                    w_err;
  logic signed [SUM_W-1:0] w_base;
  logic signed [SUM_W-1:0] w_inc;
  logic signed [SUM_W-1:0] w_adj;
  logic signed [SUM_W-1:0] w_sum;
  tod_t                    w_next;
  logic                    w_carry;
  logic                    w_borrow;

  // A legal load takes priority; an adjust arriving alongside it is dropped and flagged.
  assign w_load_ok    = load_valid && (load_tod[NS_MSB:NS_LSB] < NS_PER_SEC);
  assign w_adj_ok     = adj_valid && adj_in_range(adj_ns) && !w_load_ok;
  assign w_period_bad = period_valid && (period_ns == 4'd0) && (period_fns == 16'd0);
  assign w_err        = (load_valid && !w_load_ok) || (adj_valid && !w_adj_ok) || w_period_bad;

  assign w_base = {2'b00, r_tod.ns, r_tod.fns};
  assign w_inc  = {30'd0, r_period_ns, r_period_fns};
  assign w_adj  = w_adj_ok ? {{2{adj_ns[31]}}, adj_ns, 16'h0000} : '0;
  assign w_sum  = w_base + w_inc + w_adj;

  tod_ns_normalize u_norm (
    .i_sum    (w_sum),
    .i_sec    (r_tod.sec),
    .o_tod    (w_next),
    .o_carry  (w_carry),
    .o_borrow (w_borrow)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tod        <= '0;
      r_tod_valid  <= 1'b0;
      r_pps        <= 1'b0;
      r_err        <= 1'b0;
      r_period_ns  <= DEF_PERIOD_NS;
      r_period_fns <= DEF_PERIOD_FNS;
    end else begin
      r_err <= w_err;
      if (w_load_ok) begin
        r_tod       <= load_tod;
        r_tod_valid <= 1'b1;
        r_pps       <= 1'b0;
      end else begin
        r_tod <= w_next;
        r_pps <= w_carry && !w_borrow;
      end
      // The increment summed this cycle already used the old period.
      if (period_valid && !w_period_bad) begin
        r_period_ns  <= period_ns;
        r_period_fns <= period_fns;
      end
    end
  end

  assign tod_out   = r_tod;
  assign tod_valid = r_tod_valid;
  assign pps       = r_pps;
  assign err       = r_err;

endmodule
